cp0_regfile_ext: RTL and testbench

Parametrised next-generation CP0 register file for the MIPS pipeline, fed from the WB stage.
- Holds Status, Cause, EPC, BadVAddr, Count and Compare.
- Adds over the previous generation:
  - synchronised external interrupt pins, with a configurable pin count;
  - a configurable Count prescaler;
  - a readable Count register;
  - a compare-match timer interrupt that cannot fire spuriously.
- Drives has_int and c0_epc to the exception and ERET redirect logic in the pipeline.

---
 rtl/cp0_regfile_ext_pkg.sv | 25 ++
 rtl/cp0_regfile_ext_timer.sv | 57 +++++
 rtl/cp0_regfile_ext.sv | 143 ++++++++++++++
 tb/tb_cp0_regfile_ext.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_regfile_ext_pkg.sv
// CP0 register numbers, exception codes and the EPC target helper shared by
// the CP0 register file and its users.
package cp0_defs;

  localparam logic [4:0] CR_BADVADDR = 5'd8;
  localparam logic [4:0] CR_COUNT    = 5'd9;
  localparam logic [4:0] CR_COMPARE  = 5'd11;
  localparam logic [4:0] CR_STATUS   = 5'd12;
  localparam logic [4:0] CR_CAUSE    = 5'd13;
  localparam logic [4:0] CR_EPC      = 5'd14;

  localparam logic [4:0] EX_INT  = 5'd0;
  localparam logic [4:0] EX_ADEL = 5'd4;
  localparam logic [4:0] EX_ADES = 5'd5;
  localparam logic [4:0] EX_SYS  = 5'd8;
  localparam logic [4:0] EX_BP   = 5'd9;
  localparam logic [4:0] EX_RI   = 5'd10;
  localparam logic [4:0] EX_OV   = 5'd12;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] epc_target(input logic bd, input logic [31:0] pc);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0_regfile_ext_timer.sv
// CP0 timer: Count prescaler, Count, Compare and the sticky timer interrupt.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  localparam logic [3:0] PRESC_MAX = 4'(COUNT_DIV - 1);

  logic [3:0]  r_presc;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic        w_tick;
  logic [31:0] w_count_inc;

  assign w_tick      = (r_presc == PRESC_MAX);
  assign w_count_inc = r_count + 32'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_presc <= '0;
      r_count <= '0;
    end else if (i_count_we) begin
      r_presc <= '0;
      r_count <= i_wdata;
    end else begin
      r_presc <= w_tick ? 4'd0 : r_presc + 4'd1;
      if (w_tick) r_count <= w_count_inc;
    end
  end

  // TI only fires on the increment into Compare, so a static match never sets it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else if (i_compare_we) begin
      r_compare <= i_wdata;
      r_ti      <= 1'b0;
    end else if (w_tick && !i_count_we && (w_count_inc == r_compare)) begin
      r_ti      <= 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_regfile_ext.sv
// CP0 register file fed from WB: Status, Cause, EPC, BadVAddr, Count, Compare,
// synchronised external interrupts and the has_int / c0_epc redirect outputs.
module cp0_regfile_ext
  import cp0_defs::*;
#(
  parameter int N_EXT_INT   = 6,
  parameter int COUNT_DIV   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 mtc0_we,
  input  logic [7:0]           c0_addr,
  input  logic [31:0]          c0_wdata,
  input  logic                 wb_ex,
  input  logic                 wb_bd,
  input  logic [4:0]           wb_excode,
  input  logic [31:0]          wb_pc,
  input  logic [31:0]          wb_badvaddr,
  input  logic                 eret_flush,
  input  logic [N_EXT_INT-1:0] ext_int,
  output logic [31:0]          rdata,
  output logic [31:0]          c0_epc,
  output logic                 has_int
);

  logic [7:0]           r_im;
  logic                 r_exl;
  logic                 r_ie;
  logic                 r_bd;
  logic [4:0]           r_excode;
  logic [1:0]           r_ip_sw;
  logic [31:0]          r_epc;
  logic [31:0]          r_badvaddr;
  logic [N_EXT_INT-1:0] r_sync [SYNC_STAGES];
  logic [N_EXT_INT-1:0] r_ext_ip;

  logic [4:0]  w_reg;
  logic        w_mtc0;
  logic        w_count_we;
  logic        w_compare_we;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic [5:0]  w_ext6;
  logic [7:0]  w_ip;
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic        w_unused_sel;

  assign w_reg        = c0_addr[7:3];
  assign w_unused_sel = ^c0_addr[2:0];
  assign w_mtc0       = mtc0_we & ~wb_ex & ~eret_flush;
  assign w_count_we   = w_mtc0 & (w_reg == CR_COUNT);
  assign w_compare_we = w_mtc0 & (w_reg == CR_COMPARE);

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk          (clk),
    .resetn       (resetn),
    .i_count_we   (w_count_we),
    .i_compare_we (w_compare_we),
    .i_wdata      (c0_wdata),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_ti         (w_ti)
  );

  // SYNC_STAGES synchroniser flops, then the IP register itself.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_ext_ip <= '0;
    end else begin
      r_sync[0] <= ext_int;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_ext_ip <= r_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    w_ext6 = '0;
    w_ext6[N_EXT_INT-1:0] = r_ext_ip;
  end

  assign w_ip = {w_ext6[5] | w_ti, w_ext6[4:0], r_ip_sw};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_excode   <= '0;
      r_ip_sw    <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
    end else if (wb_ex) begin
      r_exl    <= 1'b1;
      r_excode <= wb_excode;
      // A nested exception keeps the outer return point.
      if (!r_exl) begin
        r_bd  <= wb_bd;
        r_epc <= epc_target(wb_bd, wb_pc);
      end
      if ((wb_excode == EX_ADEL) || (wb_excode == EX_ADES)) r_badvaddr <= wb_badvaddr;
    end else if (eret_flush) begin
      r_exl <= 1'b0;
    end else if (mtc0_we) begin
      case (w_reg)
        CR_STATUS: begin
          r_im  <= c0_wdata[15:8];
          r_exl <= c0_wdata[1];
          r_ie  <= c0_wdata[0];
        end
        CR_CAUSE: r_ip_sw <= c0_wdata[9:8];
        CR_EPC:   r_epc   <= c0_wdata;
        default: ;
      endcase
    end
  end

  assign w_status = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
  assign w_cause  = {r_bd, w_ti, 14'b0, w_ip, 1'b0, r_excode, 2'b0};

  always_comb begin
    rdata = '0;
    case (w_reg)
      CR_BADVADDR: rdata = r_badvaddr;
      CR_COUNT:    rdata = w_count;
      CR_COMPARE:  rdata = w_compare;
      CR_STATUS:   rdata = w_status;
      CR_CAUSE:    rdata = w_cause;
      CR_EPC:      rdata = r_epc;
      default:     rdata = '0;
    endcase
  end

  assign c0_epc  = r_epc;
  assign has_int = (|(w_ip & r_im)) & r_ie & ~r_exl;

endmodule

// File: tb/tb_cp0_regfile_ext.sv
// Randomised and directed bench for cp0_regfile_ext against a behavioural CP0 model.
module tb_cp0_regfile_ext;
  import cp0_defs::*;

  localparam int N   = 6;
  localparam int DIV = 2;
  localparam int S   = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          mtc0_we = 1'b0;
  logic [7:0]    c0_addr = '0;
  logic [31:0]   c0_wdata = '0;
  logic          wb_ex = 1'b0;
  logic          wb_bd = 1'b0;
  logic [4:0]    wb_excode = '0;
  logic [31:0]   wb_pc = '0;
  logic [31:0]   wb_badvaddr = '0;
  logic          eret_flush = 1'b0;
  logic [N-1:0]  ext_int = '0;
  logic [31:0]   rdata;
  logic [31:0]   c0_epc;
  logic          has_int;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  cp0_regfile_ext #(
    .N_EXT_INT   (N),
    .COUNT_DIV   (DIV),
    .SYNC_STAGES (S)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .mtc0_we     (mtc0_we),
    .c0_addr     (c0_addr),
    .c0_wdata    (c0_wdata),
    .wb_ex       (wb_ex),
    .wb_bd       (wb_bd),
    .wb_excode   (wb_excode),
    .wb_pc       (wb_pc),
    .wb_badvaddr (wb_badvaddr),
    .eret_flush  (eret_flush),
    .ext_int     (ext_int),
    .rdata       (rdata),
    .c0_epc      (c0_epc),
    .has_int     (has_int)
  );

  // Behavioural model: architectural fields, cycles since the last Count write,
  // and a history of sampled ext_int values.
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [4:0]  m_exc;
  logic [1:0]  m_ipsw;
  logic [31:0] m_epc, m_badv, m_count, m_compare;
  int unsigned m_cyc;
  logic [5:0]  m_q [0:S];

  logic [4:0]  m_rg;
  logic        m_wr, m_tick;
  assign m_rg   = c0_addr[7:3];
  assign m_wr   = mtc0_we && !wb_ex && !eret_flush;
  assign m_tick = ((m_cyc + 1) % DIV) == 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_im <= '0; m_exl <= 1'b0; m_ie <= 1'b0; m_bd <= 1'b0; m_ti <= 1'b0;
      m_exc <= '0; m_ipsw <= '0; m_epc <= '0; m_badv <= '0;
      m_count <= '0; m_compare <= '0; m_cyc <= 0;
      for (int i = 0; i <= S; i++) m_q[i] <= '0;
    end else begin
      if (m_wr && m_rg == CR_COUNT) begin
        m_count <= c0_wdata;
        m_cyc   <= 0;
      end else begin
        m_cyc <= m_cyc + 1;
        if (m_tick) m_count <= m_count + 32'd1;
      end
      if (m_wr && m_rg == CR_COMPARE) begin
        m_compare <= c0_wdata;
        m_ti      <= 1'b0;
      end else if (m_tick && !(m_wr && m_rg == CR_COUNT) && (m_count + 32'd1 == m_compare)) begin
        m_ti <= 1'b1;
      end
      if (wb_ex) begin
        m_exl <= 1'b1;
        m_exc <= wb_excode;
        if (!m_exl) begin
          m_bd  <= wb_bd;
          m_epc <= wb_bd ? wb_pc - 32'd4 : wb_pc;
        end
        if (wb_excode == 5'd4 || wb_excode == 5'd5) m_badv <= wb_badvaddr;
      end else if (eret_flush) begin
        m_exl <= 1'b0;
      end else if (mtc0_we) begin
        if (m_rg == CR_STATUS) begin
          m_im <= c0_wdata[15:8]; m_exl <= c0_wdata[1]; m_ie <= c0_wdata[0];
        end
        if (m_rg == CR_CAUSE) m_ipsw <= c0_wdata[9:8];
        if (m_rg == CR_EPC)   m_epc  <= c0_wdata;
      end
      m_q[0] <= 6'(ext_int);
      for (int i = 1; i <= S; i++) m_q[i] <= m_q[i-1];
    end
  end

  function automatic logic [7:0] m_ip();
    return {m_q[S][5] | m_ti, m_q[S][4:0], m_ipsw};
  endfunction

  function automatic logic m_hint();
    return (|(m_ip() & m_im)) && m_ie && !m_exl;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] rg);
    case (rg)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return {9'b0, 1'b1, 6'b0, m_im, 6'b0, m_exl, m_ie};
      5'd13:   return {m_bd, m_ti, 14'b0, m_ip(), 1'b0, m_exc, 2'b0};
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    $display("FAIL %s: event not seen within cycle budget at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    check("rdata", rdata, m_read(c0_addr[7:3]));
    check("c0_epc", c0_epc, m_epc);
    check("has_int", {31'b0, has_int}, {31'b0, m_hint()});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] r, output logic [31:0] v);
    c0_addr = {r, 3'b0};
    #1;
    v = rdata;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    mtc0_we = 1'b1; c0_addr = {r, 3'b0}; c0_wdata = d;
    step();
    mtc0_we = 1'b0;
  endtask

  task automatic exc(input logic bd, input logic [31:0] pc, input logic [4:0] code, input logic [31:0] bva);
    wb_ex = 1'b1; wb_bd = bd; wb_pc = pc; wb_excode = code; wb_badvaddr = bva;
    step();
    wb_ex = 1'b0;
  endtask

  task automatic eret();
    eret_flush = 1'b1;
    step();
    eret_flush = 1'b0;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 7))
      0: return CR_BADVADDR;
      1: return CR_COUNT;
      2: return CR_COMPARE;
      3: return CR_STATUS;
      4: return CR_CAUSE;
      5: return CR_EPC;
      6: return 5'd0;
      default: return 5'($urandom);
    endcase
  endfunction

  function automatic logic [4:0] pick_exc();
    case ($urandom_range(0, 6))
      0: return EX_INT;
      1: return EX_ADEL;
      2: return EX_ADES;
      3: return EX_SYS;
      4: return EX_BP;
      5: return EX_RI;
      default: return EX_OV;
    endcase
  endfunction

  initial begin
    logic [31:0] v, c, t;
    bit found;

    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    rd(CR_STATUS, v); check("status_after_reset", v, 32'h0040_0000);
    rd(CR_CAUSE, v);  check("cause_after_reset", v, 32'h0);
    check("has_int_after_reset", {31'b0, has_int}, 32'd0);
    found = 1'b0;
    repeat (100) begin
      step();
      rd(CR_CAUSE, t);
      if (t[30]) found = 1'b1;
    end
    check("ti_static_zero_match", {31'b0, found}, 32'd0);

    mtc0(CR_COUNT, 32'hFFFF_FFFE);
    rd(CR_COUNT, v); check("count_load", v, 32'hFFFF_FFFE);
    step(); rd(CR_COUNT, v); check("count_hold_1", v, 32'hFFFF_FFFE);
    step(); rd(CR_COUNT, v); check("count_tick_2", v, 32'hFFFF_FFFF);
    step(); step(); rd(CR_COUNT, v); check("count_wrap_4", v, 32'h0);

    mtc0(CR_COMPARE, 32'd5);
    rd(CR_CAUSE, t); check("ti_clear_on_compare", {31'b0, t[30]}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      rd(CR_COUNT, c); rd(CR_CAUSE, t);
      if (c == 32'd4) check("ti_before_match", {31'b0, t[30]}, 32'd0);
      if (c == 32'd5) begin
        check("ti_on_match", {31'b0, t[30]}, 32'd1);
        found = 1'b1;
      end else begin
        step();
      end
    end
    if (!found) timeout_fail("ti_match_timeout");
    mtc0(CR_COMPARE, 32'd5);
    rd(CR_CAUSE, t); check("ti_rewrite_clears", {31'b0, t[30]}, 32'd0);
    step(); step();
    rd(CR_CAUSE, t); check("ti_stays_clear", {31'b0, t[30]}, 32'd0);

    mtc0(CR_STATUS, 32'h0000_8001);
    rd(CR_COUNT, c);
    mtc0(CR_COMPARE, c + 32'd3);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (has_int) found = 1'b1;
      else step();
    end
    if (found) begin
      rd(CR_COUNT, v); check("count_at_timer_int", v, c + 32'd3);
    end else begin
      timeout_fail("timer_int_timeout");
    end
    exc(1'b0, 32'h8000_0180, EX_INT, 32'h0);
    check("has_int_masked_by_exl", {31'b0, has_int}, 32'd0);
    check("epc_after_int", c0_epc, 32'h8000_0180);
    eret();
    check("has_int_after_eret", {31'b0, has_int}, 32'd1);
    mtc0(CR_COMPARE, c);
    check("has_int_ti_cleared", {31'b0, has_int}, 32'd0);

    mtc0(CR_STATUS, 32'h0000_0401);
    ext_int[0] = 1'b1;
    for (int i = 1; i <= S + 1; i++) begin
      step();
      check("ext_rise_latency", {31'b0, has_int}, {31'b0, i == S + 1});
    end
    ext_int[0] = 1'b0;
    for (int i = 1; i <= S + 1; i++) begin
      step();
      check("ext_fall_latency", {31'b0, has_int}, {31'b0, i != S + 1});
    end

    exc(1'b1, 32'hBFC0_0100, EX_ADEL, 32'h1234_5671);
    check("epc_delay_slot", c0_epc, 32'hBFC0_00FC);
    rd(CR_CAUSE, v);
    check("cause_bd_set", {31'b0, v[31]}, 32'd1);
    check("cause_excode_adel", {27'b0, v[6:2]}, 32'd4);
    rd(CR_BADVADDR, v); check("badvaddr_load", v, 32'h1234_5671);
    exc(1'b0, 32'h8000_0000, EX_SYS, 32'hDEAD_BEEF);
    check("epc_nested_held", c0_epc, 32'hBFC0_00FC);
    rd(CR_CAUSE, v);
    check("cause_bd_nested_held", {31'b0, v[31]}, 32'd1);
    check("cause_excode_nested", {27'b0, v[6:2]}, 32'd8);
    rd(CR_BADVADDR, v); check("badvaddr_not_sys", v, 32'h1234_5671);
    eret();

    c0_addr = {CR_STATUS, 3'b0}; c0_wdata = 32'h0; mtc0_we = 1'b1;
    wb_ex = 1'b1; wb_bd = 1'b0; wb_excode = EX_INT; wb_pc = 32'h8000_0200;
    step();
    mtc0_we = 1'b0; wb_ex = 1'b0;
    rd(CR_STATUS, v); check("status_ex_beats_mtc0", v, 32'h0040_0403);
    check("epc_before_async_reset", c0_epc, 32'h8000_0200);
    #1 resetn = 1'b0;
    #1;
    check("status_async_reset", rdata, 32'h0040_0000);
    check("epc_async_reset", c0_epc, 32'h0);
    rd(CR_COUNT, v); check("count_async_reset", v, 32'h0);
    #1 resetn = 1'b1;
    step();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      mtc0_we = 1'b0; wb_ex = 1'b0; eret_flush = 1'b0;
      c0_addr = {pick_reg(), 3'($urandom)};
      if ($urandom_range(0, 99) < 30) begin
        mtc0_we  = 1'b1;
        c0_wdata = $urandom;
        if (c0_addr[7:3] == CR_COMPARE) c0_wdata = m_count + $urandom_range(1, 4);
        if (c0_addr[7:3] == CR_COUNT && $urandom_range(0, 1) == 0)
          c0_wdata = 32'hFFFF_FFF8 + $urandom_range(0, 7);
      end
      if ($urandom_range(0, 19) == 0) begin
        wb_ex = 1'b1; wb_bd = 1'($urandom); wb_excode = pick_exc();
        wb_pc = $urandom; wb_badvaddr = $urandom;
      end
      if ($urandom_range(0, 19) == 0) eret_flush = 1'b1;
      if ($urandom_range(0, 7) == 0) ext_int = N'($urandom);
      step();
    end

    mtc0_we = 1'b0; wb_ex = 1'b0; eret_flush = 1'b0; ext_int = '0;
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
